// File: rtl/ctrl_decode_pipe.sv
// RV32 ID-stage control decoder with a registered ID/EX control bundle,
// valid/hold handshake, load-use bubble insertion and redirect flush.
module ctrl_decode_pipe #(
    parameter int ALU_OP_W  = 6,
    parameter int ENABLE_M  = 0,
    parameter int HAZARD_EN = 1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                instr_valid_i,
    input  logic [31:0]         instruction_i,
    input  logic                flush_i,
    input  logic                ex_stall_i,
    output logic                stall_o,
    output logic                ctrl_valid_o,
    output logic                alusrc1_o,
    output logic                alusrc2_o,
    output logic [1:0]          dmem_to_reg_o,
    output logic                reg_write_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic                branch_o,
    output logic                jump_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic [4:0]          rd_o,
    output logic [2:0]          funct3_o,
    output logic                illegal_o
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = ALU_OP_W'(8);
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(9);
    localparam logic [ALU_OP_W-1:0] ALU_NOP  = ALU_OP_W'(15);

    typedef struct packed {
        logic                valid;
        logic                src1;
        logic                src2;
        logic [1:0]          d2r;
        logic                rw;
        logic                mr;
        logic                mw;
        logic                br;
        logic                jmp;
        logic [ALU_OP_W-1:0] alu;
        logic [4:0]          rd;
        logic [2:0]          f3;
        logic                ill;
    } bundle_t;

    localparam bundle_t BUBBLE = '{alu: ALU_NOP, default: '0};

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2;
    logic       alt;
    logic       is_m;
    logic       use_rs1, use_rs2;
    logic       haz;
    bundle_t    dec, q;

    assign opcode = instruction_i[6:0];
    assign rd     = instruction_i[11:7];
    assign f3     = instruction_i[14:12];
    assign rs1    = instruction_i[19:15];
    assign rs2    = instruction_i[24:20];
    assign alt    = instruction_i[30];
    assign is_m   = (instruction_i[31:25] == 7'b0000001);

    always_comb begin
        dec       = BUBBLE;
        dec.valid = 1'b1;
        dec.rd    = rd;
        dec.f3    = f3;
        use_rs1   = 1'b1;
        use_rs2   = 1'b0;
        case (opcode)
            OP_R: begin
                use_rs2 = 1'b1;
                if (is_m) begin
                    if (ENABLE_M != 0) begin
                        dec.d2r = 2'b01;
                        dec.rw  = 1'b1;
                        dec.alu = ALU_OP_W'({2'b10, f3});
                    end else begin
                        dec.ill = 1'b1;
                    end
                end else begin
                    dec.d2r = 2'b01;
                    dec.rw  = 1'b1;
                    // funct3 doubles as the ALU code except for the alt forms
                    if (f3 == 3'd0 && alt)      dec.alu = ALU_SUB;
                    else if (f3 == 3'd5 && alt) dec.alu = ALU_SRA;
                    else                        dec.alu = ALU_OP_W'(f3);
                end
            end
            OP_IMM: begin
                dec.src2 = 1'b1;
                dec.d2r  = 2'b01;
                dec.rw   = 1'b1;
                dec.alu  = (f3 == 3'd5 && alt) ? ALU_SRA : ALU_OP_W'(f3);
            end
            OP_LUI: begin
                use_rs1 = 1'b0;
                dec.d2r = 2'b11;
                dec.rw  = 1'b1;
            end
            OP_AUIPC: begin
                use_rs1  = 1'b0;
                dec.src1 = 1'b1;
                dec.src2 = 1'b1;
                dec.d2r  = 2'b01;
                dec.rw   = 1'b1;
                dec.alu  = ALU_ADD;
            end
            OP_JAL: begin
                use_rs1  = 1'b0;
                dec.src1 = 1'b1;
                dec.src2 = 1'b1;
                dec.d2r  = 2'b10;
                dec.rw   = 1'b1;
                dec.jmp  = 1'b1;
                dec.alu  = ALU_ADD;
            end
            OP_JALR: begin
                dec.src2 = 1'b1;
                dec.d2r  = 2'b10;
                dec.rw   = 1'b1;
                dec.jmp  = 1'b1;
                dec.alu  = ALU_ADD;
            end
            OP_BRANCH: begin
                use_rs2 = 1'b1;
                case (f3)
                    3'd0, 3'd1: begin dec.br = 1'b1; dec.alu = ALU_SUB;  end
                    3'd4, 3'd5: begin dec.br = 1'b1; dec.alu = ALU_SLT;  end
                    3'd6, 3'd7: begin dec.br = 1'b1; dec.alu = ALU_SLTU; end
                    default:    dec.ill = 1'b1;
                endcase
            end
            OP_LOAD: begin
                dec.src2 = 1'b1;
                dec.mr   = 1'b1;
                dec.rw   = 1'b1;
                dec.alu  = ALU_ADD;
            end
            OP_STORE: begin
                use_rs2  = 1'b1;
                dec.src2 = 1'b1;
                dec.mw   = 1'b1;
                dec.alu  = ALU_ADD;
            end
            default: dec.ill = 1'b1;
        endcase
        if (rd == 5'd0) dec.rw = 1'b0;
    end

    // Load in ID/EX whose result the ID instruction needs: insert one bubble
    always_comb begin
        haz = (HAZARD_EN != 0) && q.valid && q.mr && (q.rd != 5'd0) && instr_valid_i &&
              ((use_rs1 && rs1 == q.rd) || (use_rs2 && rs2 == q.rd));
    end

    assign stall_o = (haz | ex_stall_i) & ~flush_i;

    always_ff @(posedge clk_i) begin
        if (reset_i)            q <= BUBBLE;
        else if (flush_i)       q <= BUBBLE;
        else if (ex_stall_i)    q <= q;
        else if (haz)           q <= BUBBLE;
        else if (instr_valid_i) q <= dec;
        else                    q <= BUBBLE;
    end

    assign ctrl_valid_o  = q.valid;
    assign alusrc1_o     = q.src1;
    assign alusrc2_o     = q.src2;
    assign dmem_to_reg_o = q.d2r;
    assign reg_write_o   = q.rw;
    assign mem_read_o    = q.mr;
    assign mem_write_o   = q.mw;
    assign branch_o      = q.br;
    assign jump_o        = q.jmp;
    assign alu_op_o      = q.alu;
    assign rd_o          = q.rd;
    assign funct3_o      = q.f3;
    assign illegal_o     = q.ill;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Bench for ctrl_decode_pipe: directed test-plan steps followed by random
// traffic, both DUT flavours (M off / M on) checked against a spec-level model.
module tb_ctrl_decode_pipe;

    logic        clk = 1'b0;
    logic        reset_i, instr_valid_i, flush_i, ex_stall_i;
    logic [31:0] instruction_i;

    logic       stall[2], cv[2], s1[2], s2[2], rw[2], mr[2], mw[2], br[2], jp[2], il[2];
    logic [1:0] d2r[2];
    logic [5:0] alu[2];
    logic [4:0] rd[2];
    logic [2:0] f3[2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ctrl_decode_pipe #(.ALU_OP_W(6), .ENABLE_M(g), .HAZARD_EN(1)) u_dut (
            .clk_i(clk), .reset_i(reset_i), .instr_valid_i(instr_valid_i),
            .instruction_i(instruction_i), .flush_i(flush_i), .ex_stall_i(ex_stall_i),
            .stall_o(stall[g]), .ctrl_valid_o(cv[g]), .alusrc1_o(s1[g]), .alusrc2_o(s2[g]),
            .dmem_to_reg_o(d2r[g]), .reg_write_o(rw[g]), .mem_read_o(mr[g]),
            .mem_write_o(mw[g]), .branch_o(br[g]), .jump_o(jp[g]), .alu_op_o(alu[g]),
            .rd_o(rd[g]), .funct3_o(f3[g]), .illegal_o(il[g])
        );
    end

    typedef struct packed {
        bit       v, s1, s2;
        bit [1:0] d2r;
        bit       rw, mr, mw, br, j, ill;
        bit [5:0] alu;
        bit [4:0] rd;
        bit [2:0] f3;
    } exp_t;

    exp_t m[2];
    int   checks = 0;
    int   errors = 0;
    logic last_stall;

    function automatic exp_t bub();
        exp_t e = '0;
        e.alu = 6'd15;
        return e;
    endfunction

    // Decode straight from the instruction-set table
    function automatic exp_t dec(logic [31:0] i, bit enm);
        exp_t     e = bub();
        bit [2:0] fn = i[14:12];
        e.v = 1; e.rd = i[11:7]; e.f3 = fn;
        case (i[6:0])
            7'h33: begin
                if (i[31:25] == 7'h01) begin
                    if (enm) begin e.alu = 6'd16 + 6'(fn); e.d2r = 1; e.rw = 1; end
                    else e.ill = 1;
                end else begin
                    e.d2r = 1; e.rw = 1;
                    if (fn == 0 && i[30])      e.alu = 9;
                    else if (fn == 5 && i[30]) e.alu = 8;
                    else                       e.alu = 6'(fn);
                end
            end
            7'h13: begin e.s2 = 1; e.d2r = 1; e.rw = 1; e.alu = (fn == 5 && i[30]) ? 6'd8 : 6'(fn); end
            7'h37: begin e.d2r = 3; e.rw = 1; e.alu = 15; end
            7'h17: begin e.s1 = 1; e.s2 = 1; e.d2r = 1; e.rw = 1; e.alu = 0; end
            7'h6F: begin e.s1 = 1; e.s2 = 1; e.d2r = 2; e.rw = 1; e.j = 1; e.alu = 0; end
            7'h67: begin e.s2 = 1; e.d2r = 2; e.rw = 1; e.j = 1; e.alu = 0; end
            7'h63: begin
                if (fn == 2 || fn == 3) e.ill = 1;
                else begin e.br = 1; e.alu = (fn < 2) ? 6'd9 : (fn < 6) ? 6'd2 : 6'd3; end
            end
            7'h03: begin e.s2 = 1; e.mr = 1; e.rw = 1; e.d2r = 0; e.alu = 0; end
            7'h23: begin e.s2 = 1; e.mw = 1; e.alu = 0; end
            default: e.ill = 1;
        endcase
        if (e.rd == 0) e.rw = 0;
        return e;
    endfunction

    function automatic bit haz_m(exp_t s, bit v, logic [31:0] i);
        bit u1 = !(i[6:0] inside {7'h37, 7'h17, 7'h6F});
        bit u2 = i[6:0] inside {7'h33, 7'h63, 7'h23};
        return s.v && s.mr && s.rd != 0 && v &&
               ((u1 && i[19:15] == s.rd) || (u2 && i[24:20] == s.rd));
    endfunction

    function automatic exp_t nxt(exp_t s, bit rst, bit v, logic [31:0] i, bit fl, bit st, bit enm);
        if (rst || fl)        return bub();
        if (st)               return s;
        if (haz_m(s, v, i))   return bub();
        if (v)                return dec(i, enm);
        return bub();
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_outs();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("d%0d_valid", k), 32'(cv[k]), 32'(m[k].v));
            chk($sformatf("d%0d_alu", k), 32'(alu[k]), 32'(m[k].alu));
            chk($sformatf("d%0d_flags", k),
                32'({s1[k], s2[k], d2r[k], rw[k], mr[k], mw[k], br[k], jp[k], il[k]}),
                32'({m[k].s1, m[k].s2, m[k].d2r, m[k].rw, m[k].mr, m[k].mw, m[k].br, m[k].j, m[k].ill}));
            chk($sformatf("d%0d_rd_f3", k), 32'({rd[k], f3[k]}), 32'({m[k].rd, m[k].f3}));
        end
    endtask

    // One cycle: drive, check combinational stall, clock, check registered bundle
    task automatic cyc(input bit rst, input bit v, input logic [31:0] ins, input bit fl, input bit st);
        reset_i = rst; instr_valid_i = v; instruction_i = ins; flush_i = fl; ex_stall_i = st;
        #1;
        for (int k = 0; k < 2; k++)
            chk($sformatf("d%0d_stall", k), 32'(stall[k]),
                32'((haz_m(m[k], v, ins) | st) & ~fl));
        last_stall = stall[0];
        @(posedge clk);
        for (int k = 0; k < 2; k++) m[k] = nxt(m[k], rst, v, ins, fl, st, k[0]);
        #1;
        chk_outs();
    endtask

    function automatic logic [31:0] gen();
        logic [31:0] i = $urandom;
        case ($urandom_range(0, 11))
            0:       begin i[6:0] = 7'h33; i[31:25] = ($urandom_range(0, 2) == 0) ? 7'h20 :
                                                     ($urandom_range(0, 1) == 0) ? 7'h01 : 7'h00; end
            1:       i[6:0] = 7'h13;
            2:       i[6:0] = 7'h37;
            3:       i[6:0] = 7'h17;
            4:       i[6:0] = 7'h6F;
            5:       i[6:0] = 7'h67;
            6:       i[6:0] = 7'h63;
            7:       i[6:0] = 7'h23;
            8:       i[6:0] = ($urandom_range(0, 1) == 0) ? 7'h7F : 7'($urandom);
            default: i[6:0] = 7'h03;
        endcase
        i[11:7]  = 5'($urandom_range(0, 3));
        i[19:15] = 5'($urandom_range(0, 3));
        i[24:20] = 5'($urandom_range(0, 3));
        return i;
    endfunction

    localparam logic [31:0] ADD3  = 32'h002081B3, SUB3 = 32'h402081B3;
    localparam logic [31:0] LW5   = 32'h0000A283, ADD6 = 32'h00228333;
    localparam logic [31:0] LW0   = 32'h0000A003, BLT  = 32'h0020C063;
    localparam logic [31:0] MUL   = 32'h023100B3, OP7F = 32'h0000007F;
    localparam logic [31:0] BXX2  = 32'h0020A063, NOP  = 32'h00000013;

    initial begin
        reset_i = 1; instr_valid_i = 0; instruction_i = '0; flush_i = 0; ex_stall_i = 0;
        repeat (2) @(posedge clk);
        #1;
        m[0] = bub(); m[1] = bub();
        chk_outs();
        chk("reset_alu", 32'(alu[0]), 32'd15);
        chk("reset_stall", 32'(stall[0]), 32'd0);

        cyc(0, 1, ADD3, 0, 0); chk("add_alu", 32'(alu[0]), 0);
        cyc(0, 1, SUB3, 0, 0); chk("sub_alu", 32'(alu[0]), 9);
        chk("sub_rw", 32'(rw[0]), 1); chk("sub_d2r", 32'(d2r[0]), 1); chk("sub_valid", 32'(cv[0]), 1);

        cyc(0, 1, LW5, 0, 0);
        cyc(0, 1, ADD6, 0, 0); chk("lu_stall", 32'(last_stall), 1); chk("lu_bubble", 32'(cv[0]), 0);
        cyc(0, 1, ADD6, 0, 0); chk("lu_stall_once", 32'(last_stall), 0);
        chk("lu_add_rd", 32'(rd[0]), 6); chk("lu_add_alu", 32'(alu[0]), 0);
        cyc(0, 1, LW0, 0, 0);
        cyc(0, 1, ADD6, 0, 0); chk("lw_x0_nostall", 32'(last_stall), 0);

        cyc(0, 1, BLT, 0, 0);
        cyc(0, 1, ADD3, 0, 1); chk("hold_stall", 32'(last_stall), 1);
        chk("hold_br", 32'(br[0]), 1); chk("hold_alu", 32'(alu[0]), 2); chk("hold_f3", 32'(f3[0]), 4);
        cyc(0, 1, ADD3, 1, 1); chk("flush_stall", 32'(last_stall), 0); chk("flush_bubble", 32'(cv[0]), 0);
        cyc(0, 1, ADD3, 0, 1); chk("post_flush_hold", 32'(cv[0]), 0);

        cyc(0, 1, MUL, 0, 0);
        chk("mul_m0_ill", 32'(il[0]), 1); chk("mul_m0_alu", 32'(alu[0]), 15); chk("mul_m0_rw", 32'(rw[0]), 0);
        chk("mul_m1_alu", 32'(alu[1]), 16); chk("mul_m1_rw", 32'(rw[1]), 1);
        cyc(0, 1, OP7F, 0, 0); chk("op7f_ill", 32'(il[0]), 1); chk("op7f_valid", 32'(cv[0]), 1);
        cyc(0, 1, BXX2, 0, 0); chk("bxx2_ill", 32'(il[0]), 1); chk("bxx2_valid", 32'(cv[0]), 1);
        cyc(0, 1, NOP, 0, 0);  chk("addi_x0_rw", 32'(rw[0]), 0); chk("addi_x0_valid", 32'(cv[0]), 1);

        cyc(0, 1, LW5, 0, 0);
        cyc(1, 1, ADD6, 0, 0); chk("rst_haz_stall", 32'(last_stall), 1);
        chk("rst_haz_alu", 32'(alu[0]), 15); chk("rst_haz_valid", 32'(cv[0]), 0);
        cyc(0, 1, ADD6, 0, 0); chk("rst_stall_drop", 32'(last_stall), 0);

        for (int n = 0; n < 600; n++) begin
            int r = $urandom_range(0, 99);
            cyc(r < 2, $urandom_range(0, 9) != 0, gen(), r >= 2 && r < 8, r >= 8 && r < 20);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
